seg_scan_reader: RTL and testbench
==================================

SEG_SCAN_READER -- requirements
Module: seg_scan_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive identical cycles needed to accept a digit pattern (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port seg_in, input, 7 bits: segment lines, active-high, bit6=a through bit0=g.
REQ-005 SHALL have port dig_en, input, 4 bits: digit enables, active-high; bit k selects digit slot k, with slot 3 the most significant.
REQ-006 SHALL have port out_ready, input, 1 bit: the consumer accepts the frame.
REQ-007 SHALL have port ovf_clr, input, 1 bit: a synchronous clear of the overflow flag.
REQ-008 SHALL have port bcd_out, output, 16 bits: frame nibbles {slot3, slot2, slot1, slot0}.
REQ-009 SHALL have port err_out, output, 4 bits: per-slot invalid-pattern flags for the held frame.
REQ-010 SHALL have port out_valid, output, 1 bit: a frame is held.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag meaning a frame was dropped.

Function
REQ-012 SHALL decode patterns as follows: 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9, 0000000=blank (nibble 4'hE, no error).
REQ-013 SHALL decode any other pattern as nibble 4'hF and set that slot's error bit.
REQ-014 SHALL compare dwell as follows: each cycle, compare {dig_en, seg_in} with the previous cycle's registered copy; if equal and dig_en is one-hot, the dwell counter increments, saturating at STABLE_CYCLES; otherwise it loads 1 if dig_en is one-hot, else 0.
REQ-015 SHALL treat a dig_en value of zero or more than one bit set as no digit: it never commits.
REQ-016 SHALL commit on the cycle the dwell counter transitions to STABLE_CYCLES, i.e. the STABLE_CYCLES-th consecutive identical sample: the decoded nibble and error bit are written into slot k's staging register, and filled[k] is set.
REQ-017 SHALL commit exactly once per dwell: no re-commit while saturated; the same pattern re-commits only after a change of {dig_en, seg_in}.
REQ-018 SHALL allow a re-commit to a slot already filled: it overwrites the staging nibble, and the newest value wins.
REQ-019 SHALL implement an output FSM with states EMPTY and FULL; out_valid = (state == FULL).
REQ-020 SHALL behave in EMPTY as follows: when filled == 4'b1111 (including a commit on this cycle), load bcd_out and err_out from staging on the next edge, clear filled, and go to FULL.
REQ-021 SHALL behave in FULL as follows: out_valid && out_ready returns to EMPTY; bcd_out and err_out hold their values until the next load.
REQ-022 SHALL handle overflow as follows: in FULL without handshake, if filled reaches 4'b1111, set overflow, clear filled, discard the staged frame, and leave bcd_out unchanged.
REQ-023 SHALL handle a handshake coinciding with filled reaching 4'b1111 by loading the new frame and staying in FULL, with no overflow.
REQ-024 SHALL give a simultaneous ovf_clr and overflow event set priority.
REQ-025 SHALL give out_valid a latency of 1 cycle after the completing commit edge.
REQ-026 SHALL make every output registered, with no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, while rst_n is low, immediately force: bcd_out=16'h0000, err_out=4'h0, out_valid=0, overflow=0, state=EMPTY, filled=0, dwell counter=0, previous-sample register=0, staging=0.
REQ-028 SHALL, when reset is asserted mid-dwell or mid-frame, discard all partial state; the first commit after release requires a full STABLE_CYCLES dwell.

Verification
REQ-029 SHALL cover frame capture: STABLE_CYCLES=4; drive slots 3..0 with patterns 2, 0, 2, 5, each for 6 cycles, out_ready=0 -> out_valid rises 1 cycle after slot0's 4th stable cycle, bcd_out=16'h2025, err_out=0.
REQ-030 SHALL cover the short dwell: drive slot1 with 0110000 for 3 cycles, then dig_en=0 -> no commit, filled[1]=0, out_valid stays 0.
REQ-031 SHALL cover invalid and blank patterns: slot3=0000000, slot2=1000000, slot1=7, slot0=8 -> bcd_out=16'hEF78, err_out=4'b0100.
REQ-032 SHALL cover overflow: frame A=16'h1234 held with out_ready=0, then frame B=16'h5678 completes -> overflow=1, bcd_out stays 16'h1234; pulse ovf_clr -> overflow=0.
REQ-033 SHALL cover the coincident handshake: out_ready=1 on the same cycle frame B completes -> bcd_out=16'h5678 on the next edge, out_valid stays 1, overflow=0.
REQ-034 SHALL cover async reset: assert rst_n=0 between clock edges while FULL with 3 slots filled -> outputs are zero immediately; after release, a fresh 4-slot frame is needed for out_valid.

Source files
------------

// File: rtl/seg_scan_reader.sv
// Multiplexed 7-segment scan reader: samples a scanned display, debounces each digit slot and
// assembles complete 4-digit BCD frames behind a valid/ready output register.
module seg_scan_reader #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  dig_en,
   input  logic        out_ready,
   input  logic        ovf_clr,
   output logic [15:0] bcd_out,
   output logic [3:0]  err_out,
   output logic        out_valid,
   output logic        overflow
);

   typedef enum logic [0:0] {StEmpty, StFull} state_e;

   localparam logic [7:0] Stable = 8'(STABLE_CYCLES);

   state_e           state_q, state_d;
   logic [10:0]      sample_q;
   logic [7:0]       dwell_q, dwell_d;
   logic [3:0][3:0]  stage_q, stage_d;
   logic [3:0]       serr_q, serr_d;
   logic [3:0]       filled_q, filled_d, filled_pre;
   logic [15:0]      bcd_q, bcd_d;
   logic [3:0]       err_q, err_d;
   logic             ovf_q, ovf_d;

   logic       onehot, same, commit, frame_done;
   logic [3:0] dec_nib;
   logic       dec_err;

   always_comb begin
      dec_nib = 4'hF;
      dec_err = 1'b0;
      unique case (seg_in)
         7'b1111110: dec_nib = 4'h0;
         7'b0110000: dec_nib = 4'h1;
         7'b1101101: dec_nib = 4'h2;
         7'b1111001: dec_nib = 4'h3;
         7'b0110011: dec_nib = 4'h4;
         7'b1011011: dec_nib = 4'h5;
         7'b1011111: dec_nib = 4'h6;
         7'b1110000: dec_nib = 4'h7;
         7'b1111111: dec_nib = 4'h8;
         7'b1111011: dec_nib = 4'h9;
         7'b0000000: dec_nib = 4'hE;
         default:    dec_err = 1'b1;
      endcase
   end

   assign onehot = (dig_en != 4'd0) && ((dig_en & (dig_en - 4'd1)) == 4'd0);
   assign same   = ({dig_en, seg_in} == sample_q);
   // Commit only on the transition into saturation, so a steady pattern lands exactly once.
   assign commit = onehot && same && (dwell_q == Stable - 8'd1);

   always_comb begin
      dwell_d = 8'd0;
      if (onehot) begin
         if (!same) begin
            dwell_d = 8'd1;
         end else if (dwell_q >= Stable) begin
            dwell_d = dwell_q;
         end else begin
            dwell_d = dwell_q + 8'd1;
         end
      end
   end

   always_comb begin
      stage_d    = stage_q;
      serr_d     = serr_q;
      filled_pre = filled_q;
      if (commit) begin
         for (int k = 0; k < 4; k++) begin
            if (dig_en[k]) begin
               stage_d[k]    = dec_nib;
               serr_d[k]     = dec_err;
               filled_pre[k] = 1'b1;
            end
         end
      end
   end

   assign frame_done = (filled_pre == 4'hF);

   always_comb begin
      state_d  = state_q;
      bcd_d    = bcd_q;
      err_d    = err_q;
      filled_d = filled_pre;
      ovf_d    = ovf_clr ? 1'b0 : ovf_q;
      case (state_q)
         StEmpty: begin
            if (frame_done) begin
               bcd_d    = stage_d;
               err_d    = serr_d;
               filled_d = 4'd0;
               state_d  = StFull;
            end
         end
         StFull: begin
            if (out_ready) begin
               if (frame_done) begin
                  bcd_d    = stage_d;
                  err_d    = serr_d;
                  filled_d = 4'd0;
               end else begin
                  state_d = StEmpty;
               end
            end else if (frame_done) begin
               // Consumer still holds the previous frame: drop the new one.
               ovf_d    = 1'b1;
               filled_d = 4'd0;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StEmpty;
         sample_q <= '0;
         dwell_q  <= '0;
         stage_q  <= '0;
         serr_q   <= '0;
         filled_q <= '0;
         bcd_q    <= '0;
         err_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sample_q <= {dig_en, seg_in};
         dwell_q  <= dwell_d;
         stage_q  <= stage_d;
         serr_q   <= serr_d;
         filled_q <= filled_d;
         bcd_q    <= bcd_d;
         err_q    <= err_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bcd_out   = bcd_q;
   assign err_out   = err_q;
   assign out_valid = (state_q == StFull);
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader: table of whole frames plus hand sequences for dwell,
// overwrite, overflow, coincident handshake and asynchronous reset.
module tb_seg_scan_reader;

   localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                          S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                          S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111,
                          S9 = 7'b1111011, SB = 7'b0000000, SX = 7'b1000000;

   typedef struct {
      logic [3:0][6:0] segs;
      logic [15:0]     bcd;
      logic [3:0]      err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  seg_in = '0;
   logic [3:0]  dig_en = '0;
   logic        out_ready = 1'b0;
   logic        ovf_clr = 1'b0;
   logic [15:0] bcd_out;
   logic [3:0]  err_out;
   logic        out_valid;
   logic        overflow;

   int tests = 0;
   int fails = 0;
   vec_t vecs[4];

   seg_scan_reader #(.STABLE_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .seg_in    (seg_in),
      .dig_en    (dig_en),
      .out_ready (out_ready),
      .ovf_clr   (ovf_clr),
      .bcd_out   (bcd_out),
      .err_out   (err_out),
      .out_valid (out_valid),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Drive a slot/pattern for n rising edges; returns 1 time unit after the last edge.
   task automatic hold(input logic [3:0] de, input logic [6:0] sg, input int n);
      dig_en = de;
      seg_in = sg;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Slots 3..1 fully, slot0 one cycle short of its commit.
   task automatic pre_frame(input logic [3:0][6:0] segs);
      for (int k = 3; k >= 1; k--) hold(4'b0001 << k, segs[k], 6);
      hold(4'b0001, segs[0], 3);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      hold(4'b0000, SB, 1);
      out_ready = 1'b0;
      check("consume_valid", {15'd0, out_valid}, 16'd0);
   endtask

   initial begin
      vecs[0] = '{segs: {S2, S0, S2, S5}, bcd: 16'h2025, err: 4'b0000};
      vecs[1] = '{segs: {SB, SX, S7, S8}, bcd: 16'hEF78, err: 4'b0100};
      vecs[2] = '{segs: {S9, S6, S3, S4}, bcd: 16'h9634, err: 4'b0000};
      vecs[3] = '{segs: {S0, S1, S8, SB}, bcd: 16'h018E, err: 4'b0000};

      repeat (2) @(posedge clk);
      #1;
      check("rst_bcd", bcd_out, 16'h0000);
      check("rst_err", {12'd0, err_out}, 16'd0);
      check("rst_valid", {15'd0, out_valid}, 16'd0);
      check("rst_ovf", {15'd0, overflow}, 16'd0);
      rst_n = 1'b1;
      hold(4'b0000, SB, 1);

      foreach (vecs[i]) begin
         pre_frame(vecs[i].segs);
         check("vec_pre_valid", {15'd0, out_valid}, 16'd0);
         hold(4'b0001, vecs[i].segs[0], 1);
         check("vec_valid", {15'd0, out_valid}, 16'd1);
         check("vec_bcd", bcd_out, vecs[i].bcd);
         check("vec_err", {12'd0, err_out}, {12'd0, vecs[i].err});
         hold(4'b0000, SB, 1);
         consume();
      end

      // Three-cycle dwell must not fill slot1.
      hold(4'b0010, S1, 3);
      hold(4'b0000, SB, 1);
      hold(4'b1000, S4, 6);
      hold(4'b0100, S3, 6);
      hold(4'b0001, S7, 6);
      check("short_dwell_valid", {15'd0, out_valid}, 16'd0);
      hold(4'b0010, S1, 4);
      check("short_dwell_fill", {15'd0, out_valid}, 16'd1);
      check("short_dwell_bcd", bcd_out, 16'h4317);
      consume();

      // Re-commit to a filled slot: newest value wins.
      hold(4'b1000, S1, 5);
      hold(4'b1000, S9, 5);
      hold(4'b0100, S0, 6);
      hold(4'b0010, S0, 6);
      hold(4'b0001, S2, 6);
      check("overwrite_bcd", bcd_out, 16'h9002);
      consume();

      // Overflow: frame A held, frame B dropped.
      pre_frame({S1, S2, S3, S4});
      hold(4'b0001, S4, 1);
      check("frame_a_bcd", bcd_out, 16'h1234);
      hold(4'b0000, SB, 1);
      pre_frame({S5, S6, S7, S8});
      hold(4'b0001, S8, 1);
      check("ovf_set", {15'd0, overflow}, 16'd1);
      check("ovf_bcd_kept", bcd_out, 16'h1234);
      check("ovf_valid", {15'd0, out_valid}, 16'd1);
      // Set beats clear when another dropped frame completes under ovf_clr.
      hold(4'b1000, S9, 6);
      hold(4'b0100, S6, 6);
      hold(4'b0010, S3, 6);
      ovf_clr = 1'b1;
      hold(4'b0001, S4, 4);
      ovf_clr = 1'b0;
      check("ovf_priority", {15'd0, overflow}, 16'd1);
      check("ovf_priority_bcd", bcd_out, 16'h1234);
      ovf_clr = 1'b1;
      hold(4'b0000, SB, 1);
      ovf_clr = 1'b0;
      check("ovf_clr", {15'd0, overflow}, 16'd0);

      // Handshake on the same edge that frame B completes.
      pre_frame({S5, S6, S7, S8});
      out_ready = 1'b1;
      hold(4'b0001, S8, 1);
      out_ready = 1'b0;
      check("coinc_bcd", bcd_out, 16'h5678);
      check("coinc_valid", {15'd0, out_valid}, 16'd1);
      check("coinc_ovf", {15'd0, overflow}, 16'd0);

      // Async reset while FULL with three slots staged.
      hold(4'b1000, S1, 6);
      hold(4'b0100, S2, 6);
      hold(4'b0010, S3, 6);
      #3 rst_n = 1'b0;
      #1;
      check("arst_bcd", bcd_out, 16'h0000);
      check("arst_valid", {15'd0, out_valid}, 16'd0);
      check("arst_err", {12'd0, err_out}, 16'd0);
      hold(4'b0000, SB, 2);
      rst_n = 1'b1;
      hold(4'b0001, S4, 6);
      hold(4'b1000, S1, 6);
      hold(4'b0100, S2, 6);
      hold(4'b0010, S3, 3);
      check("arst_partial_valid", {15'd0, out_valid}, 16'd0);
      hold(4'b0010, S3, 1);
      check("arst_fresh_valid", {15'd0, out_valid}, 16'd1);
      check("arst_fresh_bcd", bcd_out, 16'h1234);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
